// File: rtl/mips_pkg.sv
// Shared MIPS control constants: funct/opcode fields, ALUOp classes
// and the ALU selector codes used by control, ALU and decoders.
package mips_pkg;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_JR   = 6'b001000;

  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       uns;
  } alu_dec_t;

endpackage

// File: rtl/alu_control_decoder.sv
// ALUOp/Funct to ALU selector decode, with a registered copy
// of the selector and an unsupported-code flag.
module alu_control_decoder
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [3:0] ALUControl,
  output logic [3:0] ALUControlReg,
  output logic       Unsupported
);

  function automatic alu_dec_t rtype_dec(input logic [5:0] f);
    alu_dec_t d;
    d = '{ctrl: ALU_AND, uns: 1'b0};
    case (f)
      F_ADD, F_ADDU: d.ctrl = ALU_ADD;
      F_SUB, F_SUBU: d.ctrl = ALU_SUB;
      F_AND:         d.ctrl = ALU_AND;
      F_OR:          d.ctrl = ALU_OR;
      F_NOR:         d.ctrl = ALU_NOR;
      F_SLT:         d.ctrl = ALU_SLT;
      F_JR:          d.ctrl = ALU_AND;
      default:       d.uns  = 1'b1;
    endcase
    return d;
  endfunction

  function automatic alu_dec_t imm_dec(input logic [5:0] op);
    alu_dec_t d;
    d = '{ctrl: ALU_AND, uns: 1'b0};
    case (op)
      OP_LUI:  d.ctrl = ALU_LUI;
      OP_ORI:  d.ctrl = ALU_OR;
      OP_ANDI: d.ctrl = ALU_AND;
      OP_SLTI: d.ctrl = ALU_SLT;
      default: d.uns  = 1'b1;
    endcase
    return d;
  endfunction

  alu_dec_t dec;

  // Funct is only looked at for the R-type and immediate classes
  always_comb begin
    dec = '{ctrl: ALU_ADD, uns: 1'b0};
    case (ALUOp)
      ALUOP_MEM:    dec = '{ctrl: ALU_ADD, uns: 1'b0};
      ALUOP_BRANCH: dec = '{ctrl: ALU_SUB, uns: 1'b0};
      ALUOP_RTYPE:  dec = rtype_dec(Funct);
      ALUOP_IMM:    dec = imm_dec(Funct);
      default:      dec = '{ctrl: ALU_AND, uns: 1'b0};
    endcase
  end

  assign ALUControl  = dec.ctrl;
  assign Unsupported = dec.uns;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ALUControlReg <= ALU_AND;
    else       ALUControlReg <= ALUControl;
  end

endmodule

// File: tb/tb_alu_control_decoder.sv
// Scoreboard bench for alu_control_decoder: directed, register
// and exhaustive checks against an independent table model.
module tb_alu_control_decoder;

  logic       clk;
  logic       reset;
  logic [1:0] ALUOp;
  logic [5:0] Funct;
  logic [3:0] ALUControl;
  logic [3:0] ALUControlReg;
  logic       Unsupported;

  int checks = 0;
  int errors = 0;

  logic [4:0] sb[$];
  logic [3:0] rq[$];

  alu_control_decoder dut (
    .clk(clk),
    .reset(reset),
    .ALUOp(ALUOp),
    .Funct(Funct),
    .ALUControl(ALUControl),
    .ALUControlReg(ALUControlReg),
    .Unsupported(Unsupported)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got,
                     input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Reference tables written straight from the decode list
  logic [5:0] rt_f[9] = '{6'b100000, 6'b100001, 6'b100010,
                          6'b100011, 6'b100100, 6'b100101,
                          6'b100111, 6'b101010, 6'b001000};
  logic [3:0] rt_c[9] = '{4'b0010, 4'b0010, 4'b0110,
                          4'b0110, 4'b0000, 4'b0001,
                          4'b1100, 4'b0111, 4'b0000};
  logic [5:0] im_f[4] = '{6'b001111, 6'b001101,
                          6'b001100, 6'b001010};
  logic [3:0] im_c[4] = '{4'b0011, 4'b0001,
                          4'b0000, 4'b0111};

  function automatic logic [4:0] model(input logic [1:0] op,
                                       input logic [5:0] f);
    logic [4:0] r;
    if (op == 2'b00) return 5'b0010_0;
    if (op == 2'b01) return 5'b0110_0;
    r = 5'b0000_1;
    if (op == 2'b10) begin
      for (int i = 0; i < 9; i++)
        if (rt_f[i] == f) r = {rt_c[i], 1'b0};
    end else begin
      for (int i = 0; i < 4; i++)
        if (im_f[i] == f) r = {im_c[i], 1'b0};
    end
    return r;
  endfunction

  task automatic drive_x(input logic [1:0] op,
                         input logic [4:0] exp, input string tag);
    ALUOp = op;
    Funct = 6'bxxxxxx;
    sb.push_back(exp);
    #1;
    chk(tag, {ALUControl, Unsupported}, sb.pop_front());
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input string tag);
    ALUOp = op;
    Funct = f;
    sb.push_back(model(op, f));
    #1;
    chk(tag, {ALUControl, Unsupported}, sb.pop_front());
  endtask

  initial begin
    reset = 1'b1;
    ALUOp = 2'b00;
    Funct = 6'b000000;
    #2;
    chk("reset_reg", {1'b0, ALUControlReg}, 5'b0_0000);

    drive_x(2'b00, 5'b0010_0, "mem_x");
    drive_x(2'b01, 5'b0110_0, "br_x");
    chk("model_addu", model(2'b10, 6'b100001), 5'b0010_0);
    drive(2'b10, 6'b100001, "addu");
    drive(2'b10, 6'b100010, "sub");
    drive(2'b10, 6'b001000, "jr");
    drive(2'b10, 6'b100111, "nor");
    drive(2'b10, 6'b101010, "slt");
    drive(2'b11, 6'b001111, "lui");
    drive(2'b11, 6'b001101, "ori");
    drive(2'b11, 6'b001100, "andi");
    drive(2'b11, 6'b001010, "slti");
    drive(2'b10, 6'b000000, "rt_default");
    drive(2'b11, 6'b000000, "imm_default");

    // Registered path
    @(negedge clk);
    reset = 1'b0;
    ALUOp = 2'b01;
    Funct = 6'b000000;
    rq.push_back(4'b0110);
    @(posedge clk);
    #1;
    chk("reg_capture", {1'b0, ALUControlReg}, {1'b0, rq.pop_front()});
    #2;
    reset = 1'b1;
    #1;
    chk("reg_async_rst", {1'b0, ALUControlReg}, 5'b0_0000);
    chk("comb_in_rst", {ALUControl, Unsupported}, 5'b0110_0);
    @(posedge clk);
    #1;
    chk("reg_hold_rst", {1'b0, ALUControlReg}, 5'b0_0000);
    @(negedge clk);
    reset = 1'b0;
    ALUOp = 2'b11;
    Funct = 6'b001111;
    rq.push_back(4'b0011);
    @(posedge clk);
    #1;
    chk("reg_after_rst", {1'b0, ALUControlReg}, {1'b0, rq.pop_front()});
    @(negedge clk);
    ALUOp = 2'b10;
    Funct = 6'b100111;
    rq.push_back(4'b1100);
    @(posedge clk);
    #1;
    chk("reg_nor", {1'b0, ALUControlReg}, {1'b0, rq.pop_front()});

    for (int op = 0; op < 4; op++)
      for (int f = 0; f < 64; f++)
        drive(op[1:0], f[5:0], $sformatf("ex_%0d_%02h", op, f));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
